regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised GPR file for the pipelined core: N read ports, two write ports (W0 = ALU
//   writeback, W1 = memory writeback), write-to-read bypass, R0 hardwired to zero, and a
//   Z/V/N flag register with per-flag enables. Adds a per-register busy scoreboard
//   (reserved at issue, cleared at writeback) so decode can detect RAW hazards.
// PARAMETERS
//   DATA_W     16  register width in bits
//   NUM_REGS   16  number of registers incl. R0; ADDR_W = $clog2(NUM_REGS) (localparam)
//   NUM_RD     2   number of read ports
//   NUM_FLAGS  3   flag bits (index map in regfile_pkg)
// PORTS
//   clk        in   1                clock, all state on posedge
//   rst        in   1                synchronous, active-high reset
//   rd_addr    in   NUM_RD*ADDR_W    packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data    out  NUM_RD*DATA_W    packed read data (combinational, bypassed)
//   rd_ready   out  NUM_RD           1 = source value is valid this cycle
//   wr0_en     in   1                ALU writeback enable
//   wr0_addr   in   ADDR_W           ALU writeback register
//   wr0_data   in   DATA_W           ALU writeback data
//   wr1_en     in   1                memory writeback enable
//   wr1_addr   in   ADDR_W           memory writeback register
//   wr1_data   in   DATA_W           memory writeback data
//   rsv_en     in   1                issue: mark rsv_addr busy
//   rsv_addr   in   ADDR_W           register to reserve
//   rsv_waw    out  1                rsv_en targets an already-busy reg (combinational)
//   busy_vec   out  NUM_REGS         registered scoreboard, bit 0 always 0
//   flag_in    in   NUM_FLAGS        new flag values
//   flag_en    in   NUM_FLAGS        per-flag write enables
//   flag_out   out  NUM_FLAGS        registered flags
// BEHAVIOUR
//   - Reset: all registers, busy_vec and flag_out = 0 on the first posedge with rst=1; rst
//     overrides every write/reserve/flag update in that cycle. rd_data then reads 0.
//   - Writes: commit at posedge when wrN_en=1 and addr!=0 and addr<NUM_REGS; otherwise ignored.
//   - W0 and W1 to the same address in the same cycle: W1 wins (stored and bypassed).
//   - Reads: 0-cycle latency. Priority per port: addr==0 or >=NUM_REGS -> 0;
//     else W1 match -> wr1_data; else W0 match -> wr0_data; else array value.
//   - Scoreboard: rsv_en sets busy[rsv_addr] at posedge; any write to addr clears it at
//     posedge. Reserve and write to same addr in same cycle -> busy stays 1 (new producer).
//     R0 and out-of-range addresses are never reserved.
//   - rd_ready[i] = 1 if addr==0, or !busy[addr], or a write to addr is active this cycle.
//   - rsv_waw = rsv_en & busy[rsv_addr] & (rsv_addr!=0); reserve still takes effect.
//   - Flags: flag_out[k] <= flag_in[k] when flag_en[k]; 1-cycle latency, no bypass.
//   - No X on outputs after first reset; no internal state machine beyond array/busy/flags.
// STRUCTURE
//   - regfile_pkg: DATA_W default, FLAG_Z=0, FLAG_V=1, FLAG_N=2 index constants.
//   - Sub-module regfile_rd_port (one per read port via generate): address decode,
//     bypass mux and rd_ready logic. Array, busy bits and flags stay in the top.
// TESTING
//   1. rst=1 one cycle, read every reg on both ports -> rd_data=0, rd_ready=1, flag_out=000.
//   2. wr0 R3=16'hDEAD, rd_addr0=3 same cycle -> 16'hDEAD (bypass); next cycle, wr off -> 16'hDEAD.
//   3. wr0 R5=16'h1111 and wr1 R5=16'h2222 together -> read 16'h2222 same cycle and after.
//   4. rsv R7 -> next cycle busy_vec[7]=1, rd_ready=0; wr1 R7=16'hBEEF -> rd_ready=1, data
//      16'hBEEF same cycle, busy_vec[7]=0 next; rsv R7 twice -> rsv_waw=1 on second.
//   5. wr0 R0=16'hFFFF and rsv R0 -> read R0 = 0, busy_vec[0]=0, rsv_waw=0.
//   6. flag_in=111, flag_en=010 -> flag_out=010 next cycle; rst=1 with wr0 R2=16'hAAAA -> R2 stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the GPR file: default widths and flag bit positions.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF    = 16;
    localparam int unsigned NUM_FLAGS_DEF = 3;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 2;

endpackage

// File: rtl/regfile_rd_port.sv
// One GPR read port: zero/out-of-range decode, writeback bypass and source-ready logic.
module regfile_rd_port #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              addr_valid_i,
    input  logic [DATA_W-1:0] arr_data_i,
    input  logic              busy_i,
    input  logic              wr0_ok_i,
    input  logic [ADDR_W-1:0] wr0_addr_i,
    input  logic [DATA_W-1:0] wr0_data_i,
    input  logic              wr1_ok_i,
    input  logic [ADDR_W-1:0] wr1_addr_i,
    input  logic [DATA_W-1:0] wr1_data_i,
    output logic [DATA_W-1:0] data_c_o,
    output logic              ready_c_o
);

    logic hit0;
    logic hit1;

    assign hit0 = wr0_ok_i && (wr0_addr_i == addr_i);
    assign hit1 = wr1_ok_i && (wr1_addr_i == addr_i);

    // W1 outranks W0, mirroring the store priority in the array
    always_comb begin
        data_c_o = arr_data_i;
        if (!addr_valid_i) begin
            data_c_o = '0;
        end else if (hit1) begin
            data_c_o = wr1_data_i;
        end else if (hit0) begin
            data_c_o = wr0_data_i;
        end
    end

    assign ready_c_o = !addr_valid_i || !busy_i || hit0 || hit1;

endmodule

// File: rtl/regfile_scoreboard.sv
// GPR file with two writeback ports, bypassed reads, busy scoreboard and Z/V/N flags.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned NUM_FLAGS = NUM_FLAGS_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_RD*$clog2(NUM_REGS)-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0]        rd_data,
    output logic [NUM_RD-1:0]               rd_ready,
    input  logic                            wr0_en,
    input  logic [$clog2(NUM_REGS)-1:0]     wr0_addr,
    input  logic [DATA_W-1:0]               wr0_data,
    input  logic                            wr1_en,
    input  logic [$clog2(NUM_REGS)-1:0]     wr1_addr,
    input  logic [DATA_W-1:0]               wr1_data,
    input  logic                            rsv_en,
    input  logic [$clog2(NUM_REGS)-1:0]     rsv_addr,
    output logic                            rsv_waw,
    output logic [NUM_REGS-1:0]             busy_vec,
    input  logic [NUM_FLAGS-1:0]            flag_in,
    input  logic [NUM_FLAGS-1:0]            flag_en,
    output logic [NUM_FLAGS-1:0]            flag_out
);

    localparam int unsigned ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]    mem_q [NUM_REGS];
    logic [DATA_W-1:0]    mem_d [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q;
    logic [NUM_REGS-1:0]  busy_d;
    logic [NUM_FLAGS-1:0] flag_q;
    logic [NUM_FLAGS-1:0] flag_d;
    logic                 wr0_ok;
    logic                 wr1_ok;
    logic                 rsv_ok;

    // Writable/reservable: not R0 and inside the implemented register range
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && ({{(32-ADDR_W){1'b0}}, a} < 32'(NUM_REGS));
    endfunction

    assign wr0_ok = wr0_en && addr_ok(wr0_addr);
    assign wr1_ok = wr1_en && addr_ok(wr1_addr);
    assign rsv_ok = rsv_en && addr_ok(rsv_addr);

    // Next state: W1 applied last so it wins a same-address collision;
    // a reserve is applied after write-clears so a new producer keeps the reg busy.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr0_ok) begin
            mem_d[wr0_addr]  = wr0_data;
            busy_d[wr0_addr] = 1'b0;
        end
        if (wr1_ok) begin
            mem_d[wr1_addr]  = wr1_data;
            busy_d[wr1_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
        flag_d    = (flag_q & ~flag_en) | (flag_in & flag_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
            flag_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
            flag_q <= flag_d;
        end
    end

    assign rsv_waw  = rsv_ok && busy_q[rsv_addr];
    assign busy_vec = busy_q;
    assign flag_out = flag_q;

    for (genvar g = 0; g < int'(NUM_RD); g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              ready;

        assign addr = rd_addr[g*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd_port (
            .addr_i       (addr),
            .addr_valid_i (addr_ok(addr)),
            .arr_data_i   (mem_q[addr]),
            .busy_i       (busy_q[addr]),
            .wr0_ok_i     (wr0_ok),
            .wr0_addr_i   (wr0_addr),
            .wr0_data_i   (wr0_data),
            .wr1_ok_i     (wr1_ok),
            .wr1_addr_i   (wr1_addr),
            .wr1_data_i   (wr1_data),
            .data_c_o     (data),
            .ready_c_o    (ready)
        );

        assign rd_data[g*DATA_W +: DATA_W] = data;
        assign rd_ready[g]                 = ready;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed, table-driven bench for regfile_scoreboard with hand-computed expectations.
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  rd_ready;
    logic        wr0_en;
    logic [3:0]  wr0_addr;
    logic [15:0] wr0_data;
    logic        wr1_en;
    logic [3:0]  wr1_addr;
    logic [15:0] wr1_data;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic        rsv_waw;
    logic [15:0] busy_vec;
    logic [2:0]  flag_in;
    logic [2:0]  flag_en;
    logic [2:0]  flag_out;

    int n_chk;
    int n_fail;

    regfile_scoreboard dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_waw  (rsv_waw),
        .busy_vec (busy_vec),
        .flag_in  (flag_in),
        .flag_en  (flag_en),
        .flag_out (flag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ra0, ra1;
        logic        w0e;
        logic [3:0]  w0a;
        logic [15:0] w0d;
        logic        w1e;
        logic [3:0]  w1a;
        logic [15:0] w1d;
        logic        re;
        logic [3:0]  rsa;
        logic [2:0]  fi, fe;
        logic [15:0] e_d0, e_d1;
        logic [1:0]  e_rdy;
        logic        e_waw;
        logic [15:0] e_busy;
        logic [2:0]  e_flag;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    localparam logic [2:0] F_Z = 3'(1 << FLAG_Z);
    localparam logic [2:0] F_V = 3'(1 << FLAG_V);
    localparam logic [2:0] F_N = 3'(1 << FLAG_N);

    function automatic vec_t mk(
        input logic [3:0] ra0, input logic [3:0] ra1,
        input logic w0e, input logic [3:0] w0a, input logic [15:0] w0d,
        input logic w1e, input logic [3:0] w1a, input logic [15:0] w1d,
        input logic re, input logic [3:0] rsa,
        input logic [2:0] fi, input logic [2:0] fe,
        input logic [15:0] e_d0, input logic [15:0] e_d1, input logic [1:0] e_rdy,
        input logic e_waw, input logic [15:0] e_busy, input logic [2:0] e_flag);
        vec_t v;
        v.ra0 = ra0; v.ra1 = ra1;
        v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
        v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
        v.re = re; v.rsa = rsa; v.fi = fi; v.fe = fe;
        v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_rdy = e_rdy;
        v.e_waw = e_waw; v.e_busy = e_busy; v.e_flag = e_flag;
        return v;
    endfunction

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0;
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        flag_in = '0; flag_en = '0;
        rd_addr = '0;
    endtask

    task automatic apply(input vec_t v);
        rst = 1'b0;
        rd_addr  = {v.ra1, v.ra0};
        wr0_en   = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d;
        wr1_en   = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d;
        rsv_en   = v.re;  rsv_addr = v.rsa;
        flag_in  = v.fi;  flag_en  = v.fe;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        idle();

        //        ra0 ra1 w0e w0a w0d       w1e w1a w1d       re rsa fi    fe      d0        d1        rdy    waw busy      flag
        vecs[0]  = mk(3, 0, 1, 3, 16'hDEAD, 0, 0, 16'h0,    0, 0, 3'b0, 3'b0, 16'hDEAD, 16'h0,    2'b11, 0, 16'h0000, 3'b000);
        vecs[1]  = mk(3, 5, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 3'b0, 3'b0, 16'hDEAD, 16'h0,    2'b11, 0, 16'h0000, 3'b000);
        vecs[2]  = mk(5, 3, 1, 5, 16'h1111, 1, 5, 16'h2222, 0, 0, 3'b0, 3'b0, 16'h2222, 16'hDEAD, 2'b11, 0, 16'h0000, 3'b000);
        vecs[3]  = mk(5, 5, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 3'b0, 3'b0, 16'h2222, 16'h2222, 2'b11, 0, 16'h0000, 3'b000);
        vecs[4]  = mk(7, 5, 0, 0, 16'h0,    0, 0, 16'h0,    1, 7, 3'b0, 3'b0, 16'h0,    16'h2222, 2'b11, 0, 16'h0000, 3'b000);
        vecs[5]  = mk(7, 3, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 3'b0, 3'b0, 16'h0,    16'hDEAD, 2'b10, 0, 16'h0080, 3'b000);
        vecs[6]  = mk(7, 7, 0, 0, 16'h0,    1, 7, 16'hBEEF, 0, 0, 3'b0, 3'b0, 16'hBEEF, 16'hBEEF, 2'b11, 0, 16'h0080, 3'b000);
        vecs[7]  = mk(7, 0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 3'b0, 3'b0, 16'hBEEF, 16'h0,    2'b11, 0, 16'h0000, 3'b000);
        vecs[8]  = mk(7, 0, 0, 0, 16'h0,    0, 0, 16'h0,    1, 7, 3'b0, 3'b0, 16'hBEEF, 16'h0,    2'b11, 0, 16'h0000, 3'b000);
        vecs[9]  = mk(7, 0, 0, 0, 16'h0,    0, 0, 16'h0,    1, 7, 3'b0, 3'b0, 16'hBEEF, 16'h0,    2'b10, 1, 16'h0080, 3'b000);
        // write and re-reserve R7 together: bypass ready now, busy remains for the new producer
        vecs[10] = mk(7, 3, 1, 7, 16'h1234, 0, 0, 16'h0,    1, 7, 3'b0, 3'b0, 16'h1234, 16'hDEAD, 2'b11, 1, 16'h0080, 3'b000);
        vecs[11] = mk(7, 3, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 3'b0, 3'b0, 16'h1234, 16'hDEAD, 2'b10, 0, 16'h0080, 3'b000);
        vecs[12] = mk(0, 0, 1, 0, 16'hFFFF, 0, 0, 16'h0,    1, 0, 3'b0, 3'b0, 16'h0,    16'h0,    2'b11, 0, 16'h0080, 3'b000);
        vecs[13] = mk(0, 9, 0, 0, 16'h0,    1, 9, 16'h5A5A, 0, 0, 3'b0, 3'b0, 16'h0,    16'h5A5A, 2'b11, 0, 16'h0080, 3'b000);
        vecs[14] = mk(9, 0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 3'b111, F_V, 16'h5A5A, 16'h0,   2'b11, 0, 16'h0080, 3'b000);
        vecs[15] = mk(9, 0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 3'b000, 3'b000, 16'h5A5A, 16'h0, 2'b11, 0, 16'h0080, F_V);
        vecs[16] = mk(9, 0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 3'b101, F_Z | F_N, 16'h5A5A, 16'h0, 2'b11, 0, 16'h0080, F_V);
        vecs[17] = mk(9, 0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 3'b000, F_Z, 16'h5A5A, 16'h0, 2'b11, 0, 16'h0080, 3'b111);
        vecs[18] = mk(9, 7, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 3'b000, 3'b000, 16'h5A5A, 16'h1234, 2'b01, 0, 16'h0080, 3'b110);
        vecs[19] = mk(9, 7, 1, 7, 16'h4321, 1, 9, 16'h0F0F, 0, 0, 3'b000, 3'b000, 16'h0F0F, 16'h4321, 2'b11, 0, 16'h0080, 3'b110);

        // reset, then sweep every register on both ports
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 16; r++) begin
            rd_addr = {4'(15 - r), 4'(r)};
            #1;
            chk("rst_rd_data", r, rd_data, 32'h0);
            chk("rst_rd_ready", r, 32'(rd_ready), 32'h3);
        end
        chk("rst_flag_out", 0, 32'(flag_out), 32'h0);
        chk("rst_busy_vec", 0, 32'(busy_vec), 32'h0);
        chk("rst_rsv_waw", 0, 32'(rsv_waw), 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            chk("rd_data0", i, 32'(rd_data[15:0]), 32'(vecs[i].e_d0));
            chk("rd_data1", i, 32'(rd_data[31:16]), 32'(vecs[i].e_d1));
            chk("rd_ready", i, 32'(rd_ready), 32'(vecs[i].e_rdy));
            chk("rsv_waw", i, 32'(rsv_waw), 32'(vecs[i].e_waw));
            chk("busy_vec", i, 32'(busy_vec), 32'(vecs[i].e_busy));
            chk("flag_out", i, 32'(flag_out), 32'(vecs[i].e_flag));
        end

        // reset cycle with concurrent write, reserve and flag update: all must be dropped
        @(negedge clk);
        idle();
        rst = 1'b1;
        wr0_en = 1'b1; wr0_addr = 4'd2; wr0_data = 16'hAAAA;
        rsv_en = 1'b1; rsv_addr = 4'd3;
        flag_in = 3'b111; flag_en = 3'b111;
        @(negedge clk);
        idle();
        rd_addr = {4'd7, 4'd2};
        #1;
        chk("post_rst_r2", 100, 32'(rd_data[15:0]), 32'h0);
        chk("post_rst_r7", 100, 32'(rd_data[31:16]), 32'h0);
        chk("post_rst_busy", 100, 32'(busy_vec), 32'h0);
        chk("post_rst_flag", 100, 32'(flag_out), 32'h0);
        chk("post_rst_ready", 100, 32'(rd_ready), 32'h3);

        // stored value persists after the bypass cycle ends
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 4'd15; wr0_data = 16'hC0DE;
        @(negedge clk);
        idle();
        rd_addr = {4'd15, 4'd15};
        #1;
        chk("r15_stored", 101, rd_data, 32'hC0DEC0DE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
